mem_access_unit: RTL

//  MEM-stage consumer of the EX/MEM pipeline register. Takes the latched ALU result (address),

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: drives a req/ready data-memory handshake from the EX/MEM register,
// stalls the pipeline while an access is outstanding, and holds the MEM/WB register.
module mem_access_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inResult,
    input  logic [31:0] inWriteData,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inWord,
    input  logic        inRegWrite,
    input  logic [4:0]  inRd,
    output logic        outStall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memByteEn,
    input  logic        memReady,
    input  logic [31:0] memRdata,
    output logic [31:0] outReadData,
    output logic [31:0] outAluResult,
    output logic [4:0]  outRd,
    output logic        outRegWrite,
    output logic        outMemToReg,
    output logic        outMisaligned,
    output logic        outBusError
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    // Little-endian lane select with sign extension for byte loads.
    function automatic logic [31:0] byte_extract(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hold_q, hold_d;
    logic          buserr_q, buserr_d;

    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   alu_q, alu_d;
    logic [4:0]    rd_q, rd_d;
    logic          regw_q, regw_d;
    logic          m2r_q, m2r_d;
    logic          mis_q, mis_d;
    logic          berr_q, berr_d;

    logic          memop_s, mis_s, load_s, wb_load_s, wb_berr_s;

    // Next-state, handshake and MEM/WB next-value logic.
    always_comb begin
        memop_s   = inMemRead | inMemWrite;
        mis_s     = memop_s & inWord & (inResult[1:0] != 2'b00);
        load_s    = inMemRead & ~inMemWrite;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        buserr_d  = buserr_q;
        outStall  = 1'b0;
        wb_load_s = 1'b0;
        wb_berr_s = 1'b0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = 32'h0000_0000;
        memWdata  = 32'h0000_0000;
        memByteEn = 4'b0000;

        case (state_q)
            S_IDLE: begin
                cnt_d    = {CW{1'b0}};
                buserr_d = 1'b0;
                if (memop_s && !mis_s) begin
                    outStall = 1'b1;
                    state_d  = S_ACCESS;
                end else begin
                    wb_load_s = 1'b1;
                end
            end
            S_ACCESS: begin
                outStall = 1'b1;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (memReady) begin
                    hold_d  = inWord ? memRdata : byte_extract(memRdata, inResult[1:0]);
                    state_d = S_COMPLETE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    buserr_d = 1'b1;
                    hold_d   = 32'h0000_0000;
                    state_d  = S_COMPLETE;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_COMPLETE: begin
                wb_load_s = 1'b1;
                wb_berr_s = buserr_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request is also gated by reset so a reset during ACCESS drops it at once.
        if (state_q == S_ACCESS && reset) begin
            memReq    = 1'b1;
            memWe     = inMemWrite;
            memAddr   = {inResult[31:2], 2'b00};
            memWdata  = inWord ? inWriteData : {4{inWriteData[7:0]}};
            memByteEn = inWord ? 4'b1111 : (4'b0001 << inResult[1:0]);
        end else begin
            memReq = 1'b0;
        end

        rdata_d = rdata_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        regw_d  = regw_q;
        m2r_d   = m2r_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        if (wb_load_s) begin
            rdata_d = (state_q == S_COMPLETE && load_s && !wb_berr_s) ? hold_q : 32'h0000_0000;
            alu_d   = inResult;
            rd_d    = inRd;
            regw_d  = inRegWrite & ~mis_s & ~wb_berr_s;
            m2r_d   = load_s;
            mis_d   = mis_s;
            berr_d  = wb_berr_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, timeout counter, load holding register and MEM/WB register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            hold_q   <= 32'h0000_0000;
            buserr_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            alu_q    <= 32'h0000_0000;
            rd_q     <= 5'd0;
            regw_q   <= 1'b0;
            m2r_q    <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            buserr_q <= buserr_d;
            rdata_q  <= rdata_d;
            alu_q    <= alu_d;
            rd_q     <= rd_d;
            regw_q   <= regw_d;
            m2r_q    <= m2r_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign outReadData   = rdata_q;
    assign outAluResult  = alu_q;
    assign outRd         = rd_q;
    assign outRegWrite   = regw_q;
    assign outMemToReg   = m2r_q;
    assign outMisaligned = mis_q;
    assign outBusError   = berr_q;

endmodule
